// File: rtl/pixel_scan_pkg.sv
// Shared constants, width helper and scan state type for pixel_scan_counter.
package pixel_scan_pkg;

  localparam int unsigned DefXMax      = 1920;
  localparam int unsigned DefYMax      = 1080;
  localparam int unsigned DefNumLayers = 4;

  // clog2 with a floor of 1 so single-value ranges still get a real bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/pixel_scan_counter_if.sv
// Position stream from the scan generator to the compositor.
interface pixel_scan_counter_if #(
  parameter int unsigned LW = 1,
  parameter int unsigned XW = 2,
  parameter int unsigned YW = 2
);

  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] layer;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          line_end;
  logic          frame_start;
  logic          frame_end;

  modport master (
    output out_valid, layer, x, y, line_start, line_end, frame_start, frame_end,
    input  out_ready
  );

  modport slave (
    input  out_valid, layer, x, y, line_start, line_end, frame_start, frame_end,
    output out_ready
  );

endinterface

// File: rtl/wrap_counter.sv
// Up-counter that wraps to 0 after reaching a runtime maximum.
module wrap_counter #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         at_max
);

  // Carry into the next stage is at_max & inc, formed by the parent.
  always_comb at_max = (count == max);

  // Clear dominates; otherwise count up and wrap at max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/pixel_scan_counter.sv
// Raster scan generator: layer fastest, then x, then y, over a valid/ready stream.
module pixel_scan_counter
  import pixel_scan_pkg::*;
#(
  parameter int unsigned X_MAX      = DefXMax,
  parameter int unsigned Y_MAX      = DefYMax,
  parameter int unsigned NUM_LAYERS = DefNumLayers,
  parameter int unsigned XW         = clog2_min1(X_MAX),
  parameter int unsigned YW         = clog2_min1(Y_MAX),
  parameter int unsigned LW         = clog2_min1(NUM_LAYERS),
  parameter int unsigned FCW        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [LW:0]           active_layers,
  pixel_scan_counter_if.master  bus,
  output logic                  busy,
  output logic [FCW-1:0]        frame_count
);

  localparam int unsigned AW = LW + 1;

  scan_state_e   state;
  logic          valid;
  logic [AW-1:0] num_layers;
  logic [AW-1:0] layers_clamped;

  logic [LW-1:0] layer_cnt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [LW-1:0] layer_max;
  logic          layer_at_max, x_at_max, y_at_max;
  logic          fire, x_inc, y_inc, clear;
  logic          line_end, frame_end;

  // Clamp the requested layer count into 1..NUM_LAYERS.
  always_comb begin
    layers_clamped = active_layers;
    if (active_layers == '0) begin
      layers_clamped = AW'(1);
    end else if (32'(active_layers) > NUM_LAYERS) begin
      layers_clamped = AW'(NUM_LAYERS);
    end
  end

  // Carry chain and counter control.
  always_comb begin
    fire      = valid & bus.out_ready;
    x_inc     = fire & layer_at_max;
    y_inc     = x_inc & x_at_max;
    clear     = abort | (state == IDLE);
    layer_max = LW'(num_layers - AW'(1));
  end

  wrap_counter #(.W(LW)) u_layer_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc    (fire),
    .max    (layer_max),
    .count  (layer_cnt),
    .at_max (layer_at_max)
  );

  wrap_counter #(.W(XW)) u_x_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc    (x_inc),
    .max    (XW'(X_MAX - 1)),
    .count  (x_cnt),
    .at_max (x_at_max)
  );

  wrap_counter #(.W(YW)) u_y_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .inc    (y_inc),
    .max    (YW'(Y_MAX - 1)),
    .count  (y_cnt),
    .at_max (y_at_max)
  );

  // Scan FSM with registered valid, latched layer count and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      valid       <= 1'b0;
      num_layers  <= AW'(1);
      frame_count <= '0;
    end else if (abort) begin
      state <= IDLE;
      valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= SCAN;
            valid      <= 1'b1;
            num_layers <= layers_clamped;
          end
        end
        SCAN: begin
          if (fire && frame_end) begin
            frame_count <= frame_count + FCW'(1);
            if (continuous) begin
              num_layers <= layers_clamped;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  // Output decode; markers are gated by valid.
  always_comb begin
    line_end        = valid & layer_at_max & x_at_max;
    frame_end       = line_end & y_at_max;
    bus.out_valid   = valid;
    bus.layer       = layer_cnt;
    bus.x           = x_cnt;
    bus.y           = y_cnt;
    bus.line_start  = valid & (layer_cnt == '0) & (x_cnt == '0);
    bus.line_end    = line_end;
    bus.frame_start = valid & (layer_cnt == '0) & (x_cnt == '0) & (y_cnt == '0);
    bus.frame_end   = frame_end;
    busy            = (state == SCAN);
  end

endmodule

// File: tb/tb_pixel_scan_counter.sv
// Directed bench for pixel_scan_counter at X_MAX=4, Y_MAX=3, NUM_LAYERS=2.
module tb_pixel_scan_counter;

  localparam int unsigned XM = 4;
  localparam int unsigned YM = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic [1:0]  active_layers = 2'd2;
  logic        busy;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_scan_counter_if #(.LW(1), .XW(2), .YW(2)) bus ();

  pixel_scan_counter #(
    .X_MAX      (XM),
    .Y_MAX      (YM),
    .NUM_LAYERS (2),
    .FCW        (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .continuous    (continuous),
    .active_layers (active_layers),
    .bus           (bus),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {valid, layer, x, y, line_start, line_end, frame_start, frame_end}
  function automatic logic [31:0] obs();
    return {22'd0, bus.out_valid, bus.layer, bus.x, bus.y,
            bus.line_start, bus.line_end, bus.frame_start, bus.frame_end};
  endfunction

  // Expected stream word for beat b of a frame with L layers per pixel.
  function automatic logic [31:0] exp_beat(input int b, input int l_cnt);
    int l, xx, yy, ls, le, fs, fe;
    l  = b % l_cnt;
    xx = (b / l_cnt) % XM;
    yy = b / (l_cnt * XM);
    ls = (l == 0 && xx == 0) ? 1 : 0;
    le = (l == l_cnt - 1 && xx == XM - 1) ? 1 : 0;
    fs = (ls == 1 && yy == 0) ? 1 : 0;
    fe = (le == 1 && yy == YM - 1) ? 1 : 0;
    return 32'((1 << 9) | (l << 8) | (xx << 6) | (yy << 4) | (ls << 3) | (le << 2) | (fs << 1) | fe);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int beat;
    int cyc;
    logic [15:0] ready_pat;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    check("reset_word", obs(), 32'd0);
    check("reset_fc", 32'(frame_count), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step();
    check("idle_after_reset", obs(), 32'd0);

    // Single frame, L=2, always ready
    pulse_start();
    for (int b = 0; b < 24; b++) begin
      check($sformatf("single_b%0d", b), obs(), exp_beat(b, 2));
      step();
    end
    check("single_done_valid", 32'(bus.out_valid), 32'd0);
    check("single_done_fc", 32'(frame_count), 32'd1);
    check("single_done_busy", 32'(busy), 32'd0);

    // Continuous: two back-to-back frames, drop continuous mid second frame
    continuous = 1'b1;
    pulse_start();
    for (int b = 0; b < 48; b++) begin
      check($sformatf("cont_b%0d", b), obs(), exp_beat(b % 24, 2));
      if (b == 30) continuous = 1'b0;
      step();
    end
    check("cont_done_valid", 32'(bus.out_valid), 32'd0);
    check("cont_done_fc", 32'(frame_count), 32'd3);

    // Backpressure: fixed stall pattern, outputs must hold while not ready
    ready_pat = 16'b1011_0010_1101_1001;
    beat = 0;
    cyc = 0;
    pulse_start();
    while (beat < 24 && cyc < 200) begin
      bus.out_ready = ready_pat[cyc % 16];
      check($sformatf("stall_c%0d", cyc), obs(), exp_beat(beat, 2));
      if (bus.out_ready) beat++;
      cyc++;
      step();
    end
    check("stall_beats_done", 32'(beat), 32'd24);
    bus.out_ready = 1'b1;
    check("stall_done_valid", 32'(bus.out_valid), 32'd0);
    check("stall_done_fc", 32'(frame_count), 32'd4);

    // Layer clamp: 0 -> L=1, then 7 (truncated to 3) -> L=2 on the next frame
    active_layers = 2'd0;
    continuous = 1'b1;
    pulse_start();
    for (int b = 0; b < 12; b++) begin
      check($sformatf("l1_b%0d", b), obs(), exp_beat(b, 1));
      if (b == 5) active_layers = 2'(7);
      step();
    end
    continuous = 1'b0;
    for (int b = 0; b < 24; b++) begin
      check($sformatf("l2_b%0d", b), obs(), exp_beat(b, 2));
      step();
    end
    check("clamp_done_valid", 32'(bus.out_valid), 32'd0);
    check("clamp_done_fc", 32'(frame_count), 32'd6);

    // Abort at (1,2,1) with ready and start also high
    active_layers = 2'd2;
    pulse_start();
    for (int b = 0; b < 13; b++) step();
    check("abort_pre", obs(), exp_beat(13, 2));
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("abort_word", obs(), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fc", 32'(frame_count), 32'd6);
    step();
    step();
    check("abort_stays_idle", obs(), 32'd0);
    pulse_start();
    check("abort_restart", obs(), exp_beat(0, 2));

    // Asynchronous reset between edges
    for (int b = 0; b < 5; b++) step();
    check("rst_pre", obs(), exp_beat(5, 2));
    #3;
    reset = 1'b0;
    #1;
    check("rst_async_word", obs(), 32'd0);
    check("rst_async_fc", 32'(frame_count), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    #2;
    reset = 1'b1;
    step();
    step();
    check("rst_idle", obs(), 32'd0);
    pulse_start();
    check("rst_restart", obs(), exp_beat(0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
